mips32_cycle_controller: RTL and testbench

//  Sequences the single-cycle MIPS32 datapath from one clock. Replaces the

---
 rtl/mips32_cycle_controller.sv | 103 ++++++++++
 tb/tb_mips32_cycle_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_cycle_controller.sv
// Single-clock sequencer for the MIPS32 datapath: FETCH/EXEC/WB per instruction,
// with run/halt, single-step, instruction limit and saturating activity counters.
module mips32_cycle_controller #(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_req,
  input  logic [CNT_W-1:0] instr_limit,
  input  logic             is_mem_write,
  input  logic             is_reg_write,
  input  logic             is_halt_instr,
  output logic             pc_clr,
  output logic             ir_en,
  output logic             mem_we,
  output logic             rf_we,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_PAUSE = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic             start_acc;
  logic             limit_hit;
  logic [CNT_W:0]   instr_inc;
  logic [CYC_W:0]   cycle_inc;

  // One extra bit on the increments: the carry-out marks saturation, and it
  // keeps the limit compare from matching a wrapped count of zero.
  assign instr_inc = {1'b0, instr_count} + {{CNT_W{1'b0}}, 1'b1};
  assign cycle_inc = {1'b0, cycle_count} + {{CYC_W{1'b0}}, 1'b1};
  assign limit_hit = (instr_limit != '0) && (instr_inc == {1'b0, instr_limit});
  assign start_acc = start && ((state == S_IDLE) || (state == S_HALT));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB: begin
        if (halt_req || is_halt_instr || limit_hit) state_nxt = S_HALT;
        else if (step_mode)                         state_nxt = S_PAUSE;
        else                                        state_nxt = S_FETCH;
      end
      S_PAUSE: begin
        if (halt_req)  state_nxt = S_HALT;
        else if (step) state_nxt = S_FETCH;
      end
      S_HALT:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes depend only on registered state (plus the decoded flags), never on
  // control inputs, so a request cannot clip an instruction part-way through.
  always_comb begin
    ir_en  = (state == S_FETCH);
    mem_we = (state == S_EXEC) && is_mem_write;
    rf_we  = (state == S_WB) && is_reg_write;
    pc_en  = (state == S_WB);
    busy   = (state == S_FETCH) || (state == S_EXEC) || (state == S_WB);
    halted = (state == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc_clr      <= 1'b0;
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      state  <= state_nxt;
      pc_clr <= start_acc;
      if (start_acc) begin
        instr_count <= '0;
        cycle_count <= '0;
      end else begin
        if (busy && !cycle_inc[CYC_W])
          cycle_count <= cycle_inc[CYC_W-1:0];
        if ((state == S_WB) && !instr_inc[CNT_W])
          instr_count <= instr_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mips32_cycle_controller.sv
// Directed bench for mips32_cycle_controller: per-cycle expected strobe vectors
// go into a queue and a negedge monitor pops and compares them.
module tb_mips32_cycle_controller;

  localparam int CNT_W = 8;
  localparam int CYC_W = 16;
  localparam int ST_I = 0, ST_F = 1, ST_E = 2, ST_W = 3, ST_P = 4, ST_H = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, step_mode, step, halt_req;
  logic [CNT_W-1:0] instr_limit;
  logic             is_mem_write, is_reg_write, is_halt_instr;
  logic             pc_clr, ir_en, mem_we, rf_we, pc_en, busy, halted;
  logic [CNT_W-1:0] instr_count;
  logic [CYC_W-1:0] cycle_count;

  int checks   = 0;
  int failures = 0;
  int cyc_idx  = 0;

  // {pc_clr, ir_en, mem_we, rf_we, pc_en, busy, halted}
  logic [6:0] exp_q[$];

  mips32_cycle_controller #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .halt_req(halt_req), .instr_limit(instr_limit), .is_mem_write(is_mem_write),
    .is_reg_write(is_reg_write), .is_halt_instr(is_halt_instr), .pc_clr(pc_clr),
    .ir_en(ir_en), .mem_we(mem_we), .rf_we(rf_we), .pc_en(pc_en), .busy(busy),
    .halted(halted), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [6:0] act, e;
    act = {pc_clr, ir_en, mem_we, rf_we, pc_en, busy, halted};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL strobes cycle=%0d actual=%b required=%b (pc_clr,ir_en,mem_we,rf_we,pc_en,busy,halted)",
                 cyc_idx, act, e);
      end
      cyc_idx++;
    end
  end

  function automatic logic [6:0] ev(input int st, input logic pcclr, input logic mw, input logic rw);
    logic [6:0] v;
    v = 7'b0;
    case (st)
      ST_F: v = {pcclr, 1'b1, 3'b000, 1'b1, 1'b0};
      ST_E: v = {2'b00, mw, 2'b00, 1'b1, 1'b0};
      ST_W: v = {3'b000, rw, 1'b1, 1'b1, 1'b0};
      ST_H: v = 7'b0000001;
      default: v = 7'b0;
    endcase
    return v;
  endfunction

  // driver tasks
  task automatic tick(input logic [6:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic go(input int cur_st);
    start = 1'b1;
    tick(ev(cur_st, 1'b0, 1'b0, 1'b0));
    start = 1'b0;
  endtask

  task automatic instr(input logic mw, input logic rw, input logic pcclr,
                       input logic hreq, input logic hins);
    is_mem_write  = mw;
    is_reg_write  = rw;
    is_halt_instr = hins;
    tick(ev(ST_F, pcclr, mw, rw));
    halt_req = hreq;
    tick(ev(ST_E, 1'b0, mw, rw));
    tick(ev(ST_W, 1'b0, mw, rw));
    halt_req      = 1'b0;
    is_halt_instr = 1'b0;
    is_mem_write  = 1'b0;
    is_reg_write  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
    instr_limit = '0; is_mem_write = 1'b0; is_reg_write = 1'b0; is_halt_instr = 1'b0;
    @(posedge clk);
    #1;

    // reset held two cycles
    tick(7'b0);
    tick(7'b0);
    chk("reset_instr_count", int'(instr_count), 0);
    chk("reset_cycle_count", int'(cycle_count), 0);
    rst_n = 1'b1;
    tick(7'b0);

    // free run to a limit of 18 with mixed store/regwrite flags
    instr_limit = 8'd18;
    go(ST_I);
    for (int i = 0; i < 18; i++)
      instr((i % 3) == 0, (i % 2) == 0, i == 0, 1'b0, 1'b0);
    chk("limit18_instr_count", int'(instr_count), 18);
    chk("limit18_cycle_count", int'(cycle_count), 54);
    halt_req = 1'b1;
    tick(ev(ST_H, 0, 0, 0));
    halt_req = 1'b0;
    tick(ev(ST_H, 0, 0, 0));
    chk("halt_hold_instr_count", int'(instr_count), 18);

    // single-step: pause, stray step ignored, start ignored, step+halt -> HALT
    instr_limit = '0;
    step_mode   = 1'b1;
    go(ST_H);
    chk("restart_clear_instr", int'(instr_count), 0);
    is_reg_write = 1'b1;
    tick(ev(ST_F, 1'b1, 0, 1));
    step = 1'b1;
    tick(ev(ST_E, 0, 0, 1));
    step = 1'b0;
    tick(ev(ST_W, 0, 0, 1));
    is_reg_write = 1'b0;
    for (int i = 0; i < 10; i++) tick(ev(ST_P, 0, 0, 0));
    chk("pause_cycle_hold", int'(cycle_count), 3);
    start = 1'b1;
    tick(ev(ST_P, 0, 0, 0));
    start = 1'b0;
    tick(ev(ST_P, 0, 0, 0));
    step = 1'b1;
    tick(ev(ST_P, 0, 0, 0));
    step = 1'b0;
    instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step = 1'b1; halt_req = 1'b1;
    tick(ev(ST_P, 0, 0, 0));
    step = 1'b0; halt_req = 1'b0;
    tick(ev(ST_H, 0, 0, 0));
    chk("step_instr_count", int'(instr_count), 2);
    chk("step_cycle_count", int'(cycle_count), 6);
    step_mode = 1'b0;

    // halt_req raised in EXEC of the 5th instruction
    go(ST_H);
    for (int i = 1; i <= 5; i++)
      instr(1'b0, 1'b1, i == 1, i == 5, 1'b0);
    tick(ev(ST_H, 0, 0, 0));
    chk("halt_req_instr_count", int'(instr_count), 5);
    chk("halt_req_cycle_count", int'(cycle_count), 15);

    // halt opcode on the 5th instruction; start mid-run is ignored
    go(ST_H);
    instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(ev(ST_H, 0, 0, 0));
    chk("halt_instr_instr_count", int'(instr_count), 5);
    chk("halt_instr_cycle_count", int'(cycle_count), 15);

    // reset during WB aborts the instruction
    go(ST_H);
    instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(ev(ST_F, 0, 0, 0));
    tick(ev(ST_E, 0, 0, 0));
    rst_n = 1'b0;
    tick(ev(ST_W, 0, 0, 0));
    rst_n = 1'b1;
    chk("wb_reset_instr_count", int'(instr_count), 0);
    chk("wb_reset_cycle_count", int'(cycle_count), 0);
    tick(7'b0);
    halt_req = 1'b1;
    tick(7'b0);
    halt_req = 1'b0;
    tick(7'b0);

    // run to a count of 255 via the limit
    instr_limit = 8'd255;
    go(ST_I);
    for (int i = 0; i < 255; i++) instr(1'b0, 1'b0, i == 0, 1'b0, 1'b0);
    chk("run255_instr_count", int'(instr_count), 255);
    chk("run255_cycle_count", int'(cycle_count), 765);
    tick(ev(ST_H, 0, 0, 0));

    // restart from 255 clears counters; then saturate past 255
    instr_limit = '0;
    go(ST_H);
    chk("restart255_instr_clear", int'(instr_count), 0);
    chk("restart255_cycle_clear", int'(cycle_count), 0);
    for (int i = 0; i < 257; i++) instr(1'b0, 1'b0, i == 0, i == 256, 1'b0);
    chk("saturate_instr_count", int'(instr_count), 255);
    chk("saturate_cycle_count", int'(cycle_count), 771);
    tick(ev(ST_H, 0, 0, 0));

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
